prbs_link_dbg_ctrl: RTL

Parametrised successor to the fixed 8-lane LED/reset/inject debug hookup. It sits between the VIO sync bus and the per-lane PRBS checkers/generators, all in the slow 40 MHz domain. It turns VIO command levels into clean single-event pulses and adds a per-lane error-inject mask. It also keeps saturating per-lane error counters with a selectable readout, and drives stretched front-panel LEDs so single-cycle errors are visible.

---
 rtl/prbs_dbg_pkg.sv | 23 ++
 rtl/prbs_lane_mon.sv | 57 +++++
 rtl/prbs_link_dbg_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prbs_dbg_pkg.sv
// Shared types and helpers for the PRBS link debug controller.
package prbs_dbg_pkg;

  localparam int unsigned DEF_N_CH  = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_INJ  = 2'd2
  } ctrl_state_e;

  // Smallest width w (>= 1) with 2**w >= val.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(val)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/prbs_lane_mon.sv
// Per-lane error counter with saturation and LED blanking stretch.
module prbs_lane_mon
  import prbs_dbg_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LED_HOLD = 4000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             locked,
  input  logic             err,
  output logic [CNT_W-1:0] cnt,
  output logic             led
);

  localparam int unsigned STR_W = clog2(LED_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STR_W-1:0] stretch_q, stretch_d;
  logic             led_q, led_d;
  logic             hit;

  assign hit = err & locked;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      stretch_q <= '0;
      led_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      stretch_q <= stretch_d;
      led_q     <= led_d;
    end
  end

  // Clear beats increment; an error reloads the full blanking time.
  always_comb begin
    cnt_d     = cnt_q;
    stretch_d = stretch_q;
    if (clr) begin
      cnt_d     = '0;
      stretch_d = '0;
    end else if (hit) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      stretch_d = STR_W'(LED_HOLD);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - STR_W'(1);
    end
    led_d = locked & (stretch_d == '0);
  end

  assign cnt = cnt_q;
  assign led = led_q;

endmodule

// File: rtl/prbs_link_dbg_ctrl.sv
// VIO command edge detection, reset/inject pulse FSM and error-count readout
// for N_CH PRBS lanes.
module prbs_link_dbg_ctrl
  import prbs_dbg_pkg::*;
#(
  parameter int unsigned N_CH     = DEF_N_CH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned INJ_LEN  = 1,
  parameter int unsigned RST_LEN  = 4,
  parameter int unsigned LED_HOLD = 4000000,
  parameter int unsigned SEL_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_reset,
  input  logic             cmd_inject,
  input  logic [N_CH-1:0]  cmd_inj_mask,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [N_CH-1:0]  rx_locked,
  input  logic [N_CH-1:0]  rx_err,
  output logic             prbs_reset,
  output logic [N_CH-1:0]  inject,
  output logic [N_CH-1:0]  led_fp,
  output logic [CNT_W-1:0] cnt_out,
  output logic             busy
);

  localparam int unsigned TMR_MAX = (RST_LEN > INJ_LEN) ? RST_LEN : INJ_LEN;
  localparam int unsigned TMR_W   = clog2(TMR_MAX + 1);

  ctrl_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic             rst_hist_q, rst_hist_d;
  logic             inj_hist_q, inj_hist_d;
  logic             prbs_reset_q, prbs_reset_d;
  logic [N_CH-1:0]  inject_q, inject_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  logic             rst_edge_c, inj_edge_c;
  logic [CNT_W-1:0] cnt_arr [N_CH];

  assign rst_edge_c = cmd_reset  & ~rst_hist_q;
  assign inj_edge_c = cmd_inject & ~inj_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      mask_q       <= '0;
      rst_hist_q   <= 1'b0;
      inj_hist_q   <= 1'b0;
      prbs_reset_q <= 1'b0;
      inject_q     <= '0;
      busy_q       <= 1'b0;
      cnt_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mask_q       <= mask_d;
      rst_hist_q   <= rst_hist_d;
      inj_hist_q   <= inj_hist_d;
      prbs_reset_q <= prbs_reset_d;
      inject_q     <= inject_d;
      busy_q       <= busy_d;
      cnt_out_q    <= cnt_out_d;
    end
  end

  // Pulse sequencer: edges are only accepted in IDLE, reset edge has priority.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mask_d     = mask_q;
    rst_hist_d = cmd_reset;
    inj_hist_d = cmd_inject;

    case (state_q)
      ST_IDLE: begin
        if (rst_edge_c) begin
          state_d = ST_RST;
          timer_d = TMR_W'(RST_LEN);
        end else if (inj_edge_c) begin
          state_d = ST_INJ;
          timer_d = TMR_W'(INJ_LEN);
          mask_d  = cmd_inj_mask;
        end
      end
      ST_RST, ST_INJ: begin
        if (timer_q == TMR_W'(1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    prbs_reset_d = (state_d == ST_RST);
    inject_d     = (state_d == ST_INJ) ? mask_d : '0;
    busy_d       = (state_d != ST_IDLE);
  end

  // Out-of-range selects read as zero.
  always_comb begin
    cnt_out_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(cmd_sel) == i) cnt_out_d = cnt_arr[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    prbs_lane_mon #(
      .CNT_W    (CNT_W),
      .LED_HOLD (LED_HOLD)
    ) u_mon (
      .clk    (clk),
      .reset  (reset),
      .clr    (prbs_reset_q),
      .locked (rx_locked[g]),
      .err    (rx_err[g]),
      .cnt    (cnt_arr[g]),
      .led    (led_fp[g])
    );
  end

  assign prbs_reset = prbs_reset_q;
  assign inject     = inject_q;
  assign busy       = busy_q;
  assign cnt_out    = cnt_out_q;

endmodule
